contador_bcd_9999: RTL
======================

Name: contador_bcd_9999

Overview:
- Four-digit BCD counter, range 0000–9999, with up/down counting, a built-in tick prescaler, synchronous clear and parallel load.
- Sits directly upstream of the per-digit seven-segment decoders.
- Each 4-bit digit output (Z0..Z3) drives one decoder input; Z3 is the most significant digit.
- Digit outputs always hold valid BCD (0–9), so the decoders' A–F patterns never appear during normal operation.

Parameters:
- DIV, 50000000, clock cycles per count tick (1 Hz at 50 MHz); legal range 1 to 2^26-1.
- CW, 26, prescaler counter width; must satisfy 2^CW > DIV.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; gates both the prescaler and counting.
- up_dn  input  1  1 = count up, 0 = count down; sampled on tick cycles.
- clr  input  1  synchronous clear to 0000.
- load  input  1  synchronous parallel load request.
- load_val  input  16  BCD load value; [15:12] maps to Z3, [3:0] maps to Z0.
- Z0  output  4  units digit.
- Z1  output  4  tens digit.
- Z2  output  4  hundreds digit.
- Z3  output  4  thousands digit.
- tick  output  1  one-cycle pulse on the cycle a count step is applied.
- wrap  output  1  one-cycle pulse when the count wraps: 9999→0000 going up, or 0000→9999 going down.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Z0..Z3 = 0; prescaler = 0.
  - tick, wrap and load_err = 0.
  - Outputs hold these values until the first rising edge after rst_n deasserts.
- Prescaler:
  - When en=1, it increments every cycle.
  - On reaching DIV-1 it returns to 0 and the internal tick asserts for that cycle.
  - When en=0, it holds its value (no reset) and tick=0.
  - DIV=1 gives a tick every enabled cycle.
- Count step (tick cycle only), up direction:
  - Z0 increments; 9 wraps to 0 and carries into Z1, rippling through Z3.
  - All digit updates occur in the same edge, so there is no intermediate value.
- Count step, down direction:
  - Z0 decrements; 0 wraps to 9 and borrows from Z1, rippling similarly.
- wrap:
  - Asserts on the same edge the digits change to 0000 (up) or 9999 (down).
  - One cycle wide.
- Control priority per edge: clr > load > count step.
- clr=1:
  - Digits go to 0; prescaler resets to 0; tick is suppressed.
  - wrap and load_err stay 0.
- load=1 with all four nibbles of load_val ≤ 9:
  - Digits take load_val next edge; prescaler resets to 0; tick is suppressed.
- load=1 with any nibble > 9:
  - Digits and prescaler are unchanged.
  - load_err pulses for one cycle.
  - No count step occurs that cycle, even if a tick was due; the prescaler still advances.
- Direction change: up_dn may toggle on any cycle; only its value on a tick cycle matters.
- Outputs are registered with no combinational path from inputs to Z*, and one edge of latency from a tick, clr or load to the new digit value.
- en=0 freezes the digits, but clr and load still act.
- Digit registers never hold values > 9.

Test Plan:
- Reset and prescaler (DIV=4): assert rst_n=0 mid-count → Z3..Z0 = 0000 immediately, without a clock. Then release with en=1, up_dn=1 → tick every 4th cycle; Z0 reads 1,2,3 after ticks 1–3.
- Up carry and wrap (DIV=1): load 0x0998, count up → 0999, 1000 (single edge, Z1/Z2 carry). Then load 0x9999, one tick → 0000 with wrap=1 for exactly one cycle.
- Down borrow and wrap (DIV=1, up_dn=0): load 0x1000, one tick → 0999. Load 0x0000, one tick → 9999 with wrap=1.
- Invalid load: load_val=0x12A4, load=1 → digits unchanged, load_err=1 for one cycle. Then load_val=0x1234 → Z3..Z0 = 1,2,3,4 next edge, load_err=0.
- Priority and freeze: clr=1 and load=1 together with a tick due → 0000, tick=0, wrap=0. Then with en=0 for 20 cycles → digits and prescaler hold. After re-enable → the first tick arrives DIV minus the held prescaler count cycles later.
- Random regression: 10k random cycles of en/up_dn/clr/load, compared against a reference integer model mod 10000 → every Z digit is 0–9 on every cycle and matches the model.

Source files
------------

// File: rtl/contador_bcd_9999.sv
// Four-digit BCD up/down counter (0000-9999) with tick prescaler, synchronous clear and
// parallel load; digit outputs feed the seven-segment decoders directly.
module contador_bcd_9999 #(
  parameter int unsigned DIV = 50000000,
  parameter int unsigned CW  = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up_dn,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  Z0,
  output logic [3:0]  Z1,
  output logic [3:0]  Z2,
  output logic [3:0]  Z3,
  output logic        tick,
  output logic        wrap,
  output logic        load_err
);

  localparam logic [CW-1:0] PreMax = CW'(DIV - 1);

  logic [3:0][3:0] dig_q, dig_d, dig_step;
  logic [CW-1:0]   pre_q, pre_d, pre_inc;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            err_q, err_d;
  logic            tick_due;
  logic            load_ok;
  logic [4:0]      ripple;

  assign tick_due = en && (pre_q == PreMax);
  assign pre_inc  = (pre_q == PreMax) ? '0 : pre_q + CW'(1);

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Carry/borrow ripples through all digits combinationally so one edge applies the full step.
  always_comb begin
    ripple[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dig_step[i]  = dig_q[i];
      ripple[i+1]  = 1'b0;
      if (ripple[i]) begin
        if (up_dn) begin
          if (dig_q[i] == 4'd9) begin
            dig_step[i] = 4'd0;
            ripple[i+1] = 1'b1;
          end else begin
            dig_step[i] = dig_q[i] + 4'd1;
          end
        end else begin
          if (dig_q[i] == 4'd0) begin
            dig_step[i] = 4'd9;
            ripple[i+1] = 1'b1;
          end else begin
            dig_step[i] = dig_q[i] - 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    dig_d  = dig_q;
    pre_d  = pre_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (clr) begin
      dig_d = '0;
      pre_d = '0;
    end else if (load && load_ok) begin
      dig_d = load_val;
      pre_d = '0;
    end else begin
      if (en) pre_d = pre_inc;
      // A rejected load swallows any tick due this cycle.
      if (load) begin
        err_d = 1'b1;
      end else if (tick_due) begin
        dig_d  = dig_step;
        tick_d = 1'b1;
        wrap_d = ripple[4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q  <= '0;
      pre_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dig_q  <= dig_d;
      pre_q  <= pre_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Z0       = dig_q[0];
  assign Z1       = dig_q[1];
  assign Z2       = dig_q[2];
  assign Z3       = dig_q[3];
  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule
